reg_file_sb: RTL

- Parametrised register bank for the 8-bit processor datapath; next generation of the 4-entry single-port bank.
- Provides two combinational read ports, one clocked write port and optional write-to-read bypass.
- Adds a per-register busy scoreboard so multi-cycle producers (memory loads) can reserve a destination and the decode stage can stall on hazards.
- Sits between decode (read addresses, lock) and write-back (write port).

---
 rtl/regbank_pkg.sv | 15 +
 rtl/reg_file_sb_if.sv | 35 +++
 rtl/reg_scoreboard.sv | 61 ++++++
 rtl/reg_file_sb.sv | 75 +++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the processor register bank: default widths and the
// architectural register names used by both the decoder and the bank.
package regbank_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [DEF_ADDR_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    T0 = 2'd2,
    T1 = 2'd3
  } regName_t;

endpackage : regbank_pkg

// File: rtl/reg_file_sb_if.sv
// Decode/write-back side bundle of the scoreboarded register bank.
// The master is the pipeline; the slave is the register bank.
interface reg_file_sb_if
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0]      rd_addr_a;
  logic [ADDR_W-1:0]      rd_addr_b;
  logic [DATA_W-1:0]      rd_data_a;
  logic [DATA_W-1:0]      rd_data_b;
  logic                   busy_a;
  logic                   busy_b;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   lock_en;
  logic [ADDR_W-1:0]      lock_addr;
  logic                   lock_grant;
  logic [(2**ADDR_W)-1:0] busy_vec;
  logic [ADDR_W:0]        busy_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, lock_grant, busy_vec, busy_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, lock_en, lock_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, lock_grant, busy_vec, busy_cnt
  );

endinterface : reg_file_sb_if

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard: grants reservations for multi-cycle producers
// and releases them on write-back, tracking the number of reserved registers.
module reg_scoreboard
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lock_en,
  input  logic [ADDR_W-1:0]      lock_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  output logic                   lock_grant,
  output logic [(2**ADDR_W)-1:0] busy_vec,
  output logic [ADDR_W:0]        busy_cnt
);

  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic             lockZero;
  logic             wrOk;
  logic             setBit;
  logic             incCnt;
  logic             decCnt;
  logic [NREGS-1:0] busyNext;
  logic [ADDR_W:0]  cntNext;

  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no path can infer a latch.
    lockZero   = (ZERO_REG != 0) && (lock_addr == '0);
    wrOk       = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    // A write-back in the same cycle frees the register for a new owner.
    lock_grant = lock_en && (!busy_vec[lock_addr] || (wr_en && (wr_addr == lock_addr)));
    setBit     = lock_grant && !lockZero;
    incCnt     = setBit && !busy_vec[lock_addr];
    decCnt     = wrOk && busy_vec[wr_addr] && !(setBit && (lock_addr == wr_addr));

    busyNext = busy_vec;
    if (wrOk)   busyNext[wr_addr]   = 1'b0;
    if (setBit) busyNext[lock_addr] = 1'b1;

    cntNext = busy_cnt;
    if (incCnt && !decCnt)      cntNext = busy_cnt + CNT_ONE;
    else if (decCnt && !incCnt) cntNext = busy_cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      busy_vec <= '0;
      busy_cnt <= '0;
    end else begin
      busy_vec <= busyNext;
      busy_cnt <= cntNext;
    end
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Register bank with two combinational read ports, one clocked write port,
// optional write-to-read bypass and a busy scoreboard for hazard stalls.
module reg_file_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              wrOk;
  logic              bypassOk;

  assign wrOk     = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
  // Forwarding is suppressed under reset so outputs read zero while rst_n is low.
  assign bypassOk = (BYPASS != 0) && wrOk && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array is reset because software relies on every register reading zero after reset.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wrOk) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    bus.rd_data_a = regs[bus.rd_addr_a];
    bus.rd_data_b = regs[bus.rd_addr_b];
    bus.busy_a    = bus.busy_vec[bus.rd_addr_a];
    bus.busy_b    = bus.busy_vec[bus.rd_addr_b];

    if (bypassOk && (bus.wr_addr == bus.rd_addr_a)) begin
      bus.rd_data_a = bus.wr_data;
      bus.busy_a    = 1'b0;
    end
    if (bypassOk && (bus.wr_addr == bus.rd_addr_b)) begin
      bus.rd_data_b = bus.wr_data;
      bus.busy_b    = 1'b0;
    end

    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) begin
      bus.rd_data_a = '0;
      bus.busy_a    = 1'b0;
    end
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) begin
      bus.rd_data_b = '0;
      bus.busy_b    = 1'b0;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock_en    (bus.lock_en),
    .lock_addr  (bus.lock_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .lock_grant (bus.lock_grant),
    .busy_vec   (bus.busy_vec),
    .busy_cnt   (bus.busy_cnt)
  );

endmodule : reg_file_sb
